rcu_pll_seq: RTL and testbench
==============================

// Module: rcu_pll_seq
// PURPOSE
//   Sequencer for the RCU clock generator PLL. Accepts a new clock config over a valid/ready handshake.
//   Parks the system clock on the ref clock, then power-cycles the PLL with the new config.
//   Waits for a qualified lock, then switches the clock select to the PLL output.
//   Runs on the ref clock. Sits between the RCU config registers and the PLL/clock-mux.
// PARAMETERS
//   CFG_WIDTH    3     width of PLL config word; cfg==0 means "bypass: PLL off, run on ref"
//   SW_GAP       4     cycles held after each clk_sel/pll_en change before next step (>=1)
//   LOCK_TMO     4096  max cycles from pll_en rise to synced lock before error (>=2)
//   STABLE_CYC   256   consecutive synced-lock cycles required before switching (>=1)
// PORTS
//   clk_i        in   1          ref clock
//   rst_n_i      in   1          async active-low reset
//   cfg_i        in   CFG_WIDTH  requested PLL config
//   cfg_vld_i    in   1          cfg_i valid
//   cfg_rdy_o    out  1          controller can accept cfg (IDLE, RUN, ERR)
//   pll_en_o     out  1          PLL power/enable
//   pll_cfg_o    out  CFG_WIDTH  config applied to PLL, changes only while pll_en_o==0
//   pll_lock_i   in   1          raw PLL lock, asynchronous
//   clk_sel_o    out  1          clock mux select: 0=ref, 1=PLL
//   busy_o       out  1          sequence in progress (state not IDLE/RUN/ERR)
//   err_o        out  1          lock timeout; sticky until next accepted cfg
//   relock_o     out  1          1-cycle pulse: lock lost while in RUN
// BEHAVIOUR
//   Reset values: cfg_rdy_o=1, pll_en_o=0, pll_cfg_o=0, clk_sel_o=0, busy_o=0, err_o=0, relock_o=0; state IDLE.
//   pll_lock_i goes through a 2-flop synchronizer (lock_s). All lock decisions use lock_s and add 2 cycles of latency.
//   Accept happens on cfg_vld_i & cfg_rdy_o: cfg latched into cfg_q, err_o cleared.
//     Any other cycle: vld ignored and no queueing (requester holds vld).
//   FSM, one counter cnt, width $clog2(max(LOCK_TMO,STABLE_CYC,SW_GAP)+1):
//     IDLE     : clk_sel=0, pll_en=0. Accept with cfg!=0 -> PARK. Accept with cfg==0 -> IDLE (pll_cfg_o<=0).
//     RUN      : clk_sel=1, pll_en=1. Accept with cfg==pll_cfg_o -> RUN (no-op).
//                Accept with other cfg!=0 -> PARK. Accept with cfg==0 -> PARK, then OFF -> IDLE.
//                lock_s==0 -> clk_sel<=0 next cycle, relock_o pulse, cfg_q=pll_cfg_o, -> PARK.
//                Lock loss has priority over a same-cycle accept, and that accept is rejected (cfg_rdy_o=0 that cycle).
//     PARK     : clk_sel=0; wait SW_GAP cycles -> OFF.
//     OFF      : pll_en=0, pll_cfg_o<=cfg_q on entry; wait SW_GAP cycles. Then IDLE if cfg_q==0, else LOCK.
//     LOCK     : pll_en=1; cnt counts up. lock_s=1 -> STAB (cnt cleared). cnt==LOCK_TMO-1 and no lock -> ERR.
//     STAB     : cnt counts consecutive lock_s=1 cycles. lock_s=0 -> LOCK with the timeout count restarted.
//                cnt==STABLE_CYC-1 -> SWCH.
//     SWCH     : clk_sel<=1; wait SW_GAP cycles -> RUN.
//     ERR      : pll_en=0, clk_sel=0, err_o=1. Accept -> PARK with the new cfg (cfg==0 -> IDLE path).
//   cfg_rdy_o = state in {IDLE, RUN, ERR} and no lock-loss this cycle. busy_o = !cfg_rdy_o except in RUN-loss.
//   Invariants: clk_sel_o=1 only if pll_en_o=1. pll_cfg_o never changes while pll_en_o=1.
//     clk_sel_o and pll_en_o never toggle in the same cycle.
//   Best-case latency from accept in IDLE to clk_sel_o=1:
//     SW_GAP (PARK) + SW_GAP (OFF) + 1 + sync 2 + lock delay + STABLE_CYC + 1 cycles.
//   Reset mid-sequence: all outputs return to reset values asynchronously, with no ordering requirement.
// STRUCTURE
//   rcu_pkg: state enum pll_seq_state_e (IDLE, PARK, OFF, LOCK, STAB, SWCH, RUN, ERR).
//     Also holds CFG_BYPASS='0 and the default parameter constants.
//   Sub-module rcu_sync2 (generic 2-flop synchronizer, reset to 0) for pll_lock_i.
//   Everything else is a single-process FSM plus one shared counter in this file.
// TESTING
//   (defaults lowered for sim: SW_GAP=2, LOCK_TMO=32, STABLE_CYC=8)
//   Cold start: cfg=3 accepted, PLL model locks 5 cyc after en.
//     -> pll_cfg_o=3 before pll_en_o=1; clk_sel_o=1 at accept+2+2+1+2+5+8+1; relock_o never pulses.
//   Reconfig in RUN: cfg 3->5.
//     -> clk_sel_o falls the next cycle; pll_en_o falls 2 cyc later; pll_cfg_o=5 while en=0;
//        relock completes; same cfg=5 again -> no output change.
//   Timeout: lock never asserts.
//     -> ERR after 32 cycles of LOCK, err_o=1, pll_en_o=0, clk_sel_o=0, cfg_rdy_o=1;
//        next accept clears err_o.
//   Unstable lock: lock drops at 5th STAB cycle.
//     -> back to LOCK, clk_sel_o stays 0, then 8 clean cycles -> switch.
//   Lock loss in RUN with cfg_vld_i high the same cycle.
//     -> relock_o 1-cycle pulse, clk_sel_o=0 next cycle, vld not accepted, re-lock with old cfg.
//   Bypass plus reset: cfg=0 from RUN -> IDLE with pll_en_o=0.
//     rst_n_i low during LOCK -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rcu_pkg.sv
// Shared types and constants for the RCU PLL sequencer.
package rcu_pkg;

  // Sequencer states, in rough order of a full reconfiguration.
  typedef enum logic [2:0] {
    IDLE,
    PARK,
    OFF,
    LOCK,
    STAB,
    SWCH,
    RUN,
    ERR
  } pll_seq_state_e;

  // A config word of all zeros means "PLL off, system runs on the ref clock".
  localparam int CFG_BYPASS = 0;

  // Default parameter values for the sequencer.
  localparam int DEF_CFG_WIDTH  = 3;
  localparam int DEF_SW_GAP     = 4;
  localparam int DEF_LOCK_TMO   = 4096;
  localparam int DEF_STABLE_CYC = 256;

  // Largest of three values; sizes the shared wait/timeout counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rcu_sync2.sv
// Generic two-flop synchronizer; both stages clear to 0 on reset.
module rcu_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/rcu_pll_seq.sv
// PLL power/lock/switch sequencer for the RCU clock generator (ref clock domain).
module rcu_pll_seq
  import rcu_pkg::*;
#(
  parameter int CFG_WIDTH  = DEF_CFG_WIDTH,
  parameter int SW_GAP     = DEF_SW_GAP,
  parameter int LOCK_TMO   = DEF_LOCK_TMO,
  parameter int STABLE_CYC = DEF_STABLE_CYC
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [CFG_WIDTH-1:0] cfg_i,
  input  logic                 cfg_vld_i,
  output logic                 cfg_rdy_o,
  output logic                 pll_en_o,
  output logic [CFG_WIDTH-1:0] pll_cfg_o,
  input  logic                 pll_lock_i,
  output logic                 clk_sel_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 relock_o
);

  localparam int CNT_W = $clog2(max3(LOCK_TMO, STABLE_CYC, SW_GAP) + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SW_GAP - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CFG_WIDTH-1:0] BYPASS = CFG_WIDTH'(CFG_BYPASS);

  pll_seq_state_e        state;
  logic [CNT_W-1:0]      cnt;
  logic [CFG_WIDTH-1:0]  cfg_q;
  logic                  lock_s;
  logic                  idle_like;
  logic                  lock_loss;
  logic                  accept;

  rcu_sync2 u_lock_sync (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .din   (pll_lock_i),
    .dout  (lock_s)
  );

  // Lock loss in RUN wins over a same-cycle request, so the handshake is withheld then.
  assign idle_like = (state == IDLE) || (state == RUN) || (state == ERR);
  assign lock_loss = (state == RUN) && !lock_s;
  assign cfg_rdy_o = idle_like && !lock_loss;
  assign busy_o    = !idle_like;
  assign accept    = cfg_vld_i && cfg_rdy_o;

  // Single-process sequencer: state, shared counter and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      cnt       <= '0;
      cfg_q     <= '0;
      pll_en_o  <= 1'b0;
      pll_cfg_o <= '0;
      clk_sel_o <= 1'b0;
      err_o     <= 1'b0;
      relock_o  <= 1'b0;
    end else begin
      relock_o <= 1'b0;
      if (accept) begin
        cfg_q <= cfg_i;
        err_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (cfg_i == BYPASS) begin
              pll_cfg_o <= '0;
            end else begin
              state <= PARK;
              cnt   <= '0;
            end
          end
        end
        RUN: begin
          if (lock_loss) begin
            clk_sel_o <= 1'b0;
            relock_o  <= 1'b1;
            cfg_q     <= pll_cfg_o;
            state     <= PARK;
            cnt       <= '0;
          end else if (accept && (cfg_i != pll_cfg_o)) begin
            clk_sel_o <= 1'b0;
            state     <= PARK;
            cnt       <= '0;
          end
        end
        PARK: begin
          // Mux sits on ref for a gap before the PLL is touched.
          clk_sel_o <= 1'b0;
          if (cnt == GAP_LAST) begin
            pll_en_o <= 1'b0;
            state    <= OFF;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OFF: begin
          // Config is only loaded here, where the PLL is already powered down.
          pll_en_o  <= 1'b0;
          pll_cfg_o <= cfg_q;
          if (cnt == GAP_LAST) begin
            state <= (cfg_q == BYPASS) ? IDLE : LOCK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOCK: begin
          pll_en_o <= 1'b1;
          if (lock_s) begin
            state <= STAB;
            cnt   <= '0;
          end else if (cnt == TMO_LAST) begin
            pll_en_o <= 1'b0;
            err_o    <= 1'b1;
            state    <= ERR;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STAB: begin
          // Any dropout restarts the whole timeout window in LOCK.
          pll_en_o <= 1'b1;
          if (!lock_s) begin
            state <= LOCK;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            clk_sel_o <= 1'b1;
            state     <= SWCH;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SWCH: begin
          clk_sel_o <= 1'b1;
          if (cnt == GAP_LAST) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR: begin
          pll_en_o  <= 1'b0;
          clk_sel_o <= 1'b0;
          if (accept) begin
            state <= PARK;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcu_pll_seq.sv
// Scoreboard bench for rcu_pll_seq: stimulus pushes expected output events, a monitor pops them.
module tb_rcu_pll_seq;

  localparam int CW = 3;

  localparam int M_RUN      = 0;
  localparam int M_UNSTABLE = 1;
  localparam int M_TMO      = 2;
  localparam int M_HALT     = 3;
  localparam int M_NOOP     = 4;

  localparam int EV_CFG    = 0;
  localparam int EV_EN_UP  = 1;
  localparam int EV_EN_DN  = 2;
  localparam int EV_SEL_UP = 3;
  localparam int EV_SEL_DN = 4;
  localparam int EV_ERR_UP = 5;
  localparam int EV_ERR_DN = 6;
  localparam int EV_RELOCK = 7;

  typedef struct {
    int kind;
    int cyc;
    int data;
  } ev_t;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [CW-1:0] cfg_i = '0;
  logic          cfg_vld_i = 1'b0;
  logic          pll_lock_i = 1'b0;
  logic          cfg_rdy_o, pll_en_o, clk_sel_o, busy_o, err_o, relock_o;
  logic [CW-1:0] pll_cfg_o;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  glitch_cyc = -1;
  int  en_cyc = 0;
  bit  lock_en = 1'b1;
  ev_t exp_q[$];

  logic [CW-1:0] p_cfg;
  logic          p_en, p_sel, p_err;

  rcu_pll_seq #(
    .CFG_WIDTH  (CW),
    .SW_GAP     (2),
    .LOCK_TMO   (32),
    .STABLE_CYC (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .cfg_i      (cfg_i),
    .cfg_vld_i  (cfg_vld_i),
    .cfg_rdy_o  (cfg_rdy_o),
    .pll_en_o   (pll_en_o),
    .pll_cfg_o  (pll_cfg_o),
    .pll_lock_i (pll_lock_i),
    .clk_sel_o  (clk_sel_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .relock_o   (relock_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  // PLL model: lock is high once en has been high for more than 5 cycles, with an optional 1-cycle dropout.
  always @(posedge clk_i) begin
    #1;
    if (!pll_en_o) en_cyc = 0;
    else en_cyc++;
    pll_lock_i = lock_en && (en_cyc > 5) && (cyc != glitch_cyc);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  function automatic string ev_name(input int k);
    case (k)
      EV_CFG:    return "cfg";
      EV_EN_UP:  return "en_up";
      EV_EN_DN:  return "en_dn";
      EV_SEL_UP: return "sel_up";
      EV_SEL_DN: return "sel_dn";
      EV_ERR_UP: return "err_up";
      EV_ERR_DN: return "err_dn";
      EV_RELOCK: return "relock";
      default:   return "none";
    endcase
  endfunction

  function automatic void push(input int k, input int c, input int d);
    exp_q.push_back('{k, c, d});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic take_ev(input int kind, input int data);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL ev_unexpected: got %s data=%0d at cyc %0d, required no event", ev_name(kind), data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.data != data) begin
        bad++;
        $display("FAIL ev_match: got %s data=%0d cyc=%0d, required %s data=%0d cyc=%0d",
                 ev_name(kind), data, cyc, ev_name(e.kind), e.data, e.cyc);
      end else begin
        $display("event %s data=%0d cyc=%0d ok", ev_name(kind), data, cyc);
      end
    end
  endtask

  // Monitor: turn output edges into events and check the invariants every cycle.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (pll_cfg_o != p_cfg) begin
        total++;
        if (p_en) begin
          bad++;
          $display("FAIL inv_cfg_stable: cfg changed to %0d while en was 1, required en=0", pll_cfg_o);
        end
        take_ev(EV_CFG, int'(pll_cfg_o));
      end
      if (pll_en_o != p_en) take_ev(pll_en_o ? EV_EN_UP : EV_EN_DN, 0);
      if (clk_sel_o != p_sel) take_ev(clk_sel_o ? EV_SEL_UP : EV_SEL_DN, clk_sel_o ? int'(pll_cfg_o) : 0);
      if (err_o != p_err) take_ev(err_o ? EV_ERR_UP : EV_ERR_DN, 0);
      if (relock_o) take_ev(EV_RELOCK, 0);
      total++;
      if (clk_sel_o && !pll_en_o) begin
        bad++;
        $display("FAIL inv_sel_en: sel=1 en=0 at cyc %0d, required en=1", cyc);
      end
      total++;
      if ((pll_en_o != p_en) && (clk_sel_o != p_sel)) begin
        bad++;
        $display("FAIL inv_toggle: en and sel both toggled at cyc %0d, required at most one", cyc);
      end
    end
    p_cfg = pll_cfg_o;
    p_en  = pll_en_o;
    p_sel = clk_sel_o;
    p_err = err_o;
  end

  // Present a cfg, wait for the handshake, and queue the events it must cause.
  task automatic send(input logic [CW-1:0] c, input int mode, input bit from_run,
                      input bit from_err, input logic [CW-1:0] oldc, output int a);
    a = -1;
    @(negedge clk_i);
    cfg_i = c;
    cfg_vld_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cfg_rdy_o) begin
        a = cyc + 1;
        break;
      end
      @(negedge clk_i);
    end
    total++;
    if (a < 0) begin
      bad++;
      $display("FAIL accept_timeout: cfg=%0d not accepted, required accept within 50 cycles", c);
    end else if (mode != M_NOOP) begin
      if (from_err) push(EV_ERR_DN, a, 0);
      if (from_run) begin
        push(EV_SEL_DN, a, 0);
        push(EV_EN_DN, a + 2, 0);
      end
      if (c != oldc) push(EV_CFG, a + 3, int'(c));
      if (c != '0) begin
        push(EV_EN_UP, a + 5, 0);
        case (mode)
          M_RUN: push(EV_SEL_UP, a + 21, int'(c));
          M_UNSTABLE: begin
            glitch_cyc = a + 15;
            push(EV_SEL_UP, a + 27, int'(c));
          end
          M_TMO: begin
            lock_en = 1'b0;
            push(EV_EN_DN, a + 36, 0);
            push(EV_ERR_UP, a + 36, 0);
          end
          default: ;
        endcase
      end
    end
    @(negedge clk_i);
    cfg_vld_i = 1'b0;
    $display("xact cfg=%0d mode=%0d accepted at cyc %0d", c, mode, a);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk_i);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL ev_missing: %0d events pending (next %s at cyc %0d), required 0",
               exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, int'(cfg_rdy_o), 1);
    chk({tag, "_en"}, int'(pll_en_o), 0);
    chk({tag, "_cfg"}, int'(pll_cfg_o), 0);
    chk({tag, "_sel"}, int'(clk_sel_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_err"}, int'(err_o), 0);
    chk({tag, "_relock"}, int'(relock_o), 0);
  endtask

  initial begin
    int a;
    int g;
    #3;
    chk_reset_vals("rst");
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Cold start from IDLE.
    send(3'd3, M_RUN, 1'b0, 1'b0, 3'd0, a);
    chk("cold_busy", int'(busy_o), 1);
    chk("cold_rdy", int'(cfg_rdy_o), 0);
    wait_done(60);
    repeat (4) @(negedge clk_i);
    chk("cold_run_sel", int'(clk_sel_o), 1);
    chk("cold_run_busy", int'(busy_o), 0);

    // Reconfigure 3 -> 5 from RUN.
    send(3'd5, M_RUN, 1'b1, 1'b0, 3'd3, a);
    wait_done(60);
    repeat (4) @(negedge clk_i);
    chk("recfg_cfg", int'(pll_cfg_o), 5);

    // Same cfg again: nothing may move.
    send(3'd5, M_NOOP, 1'b0, 1'b0, 3'd5, a);
    repeat (10) @(negedge clk_i);
    chk("noop_sel", int'(clk_sel_o), 1);
    chk("noop_rdy", int'(cfg_rdy_o), 1);

    // Lock drops in the 5th STAB cycle.
    send(3'd2, M_UNSTABLE, 1'b1, 1'b0, 3'd5, a);
    wait_done(80);
    repeat (4) @(negedge clk_i);
    glitch_cyc = -1;
    chk("unstable_sel", int'(clk_sel_o), 1);

    // Lock never arrives.
    send(3'd6, M_TMO, 1'b1, 1'b0, 3'd2, a);
    wait_done(80);
    @(negedge clk_i);
    chk("tmo_err", int'(err_o), 1);
    chk("tmo_en", int'(pll_en_o), 0);
    chk("tmo_rdy", int'(cfg_rdy_o), 1);
    chk("tmo_busy", int'(busy_o), 0);

    // Recover from ERR.
    lock_en = 1'b1;
    send(3'd3, M_RUN, 1'b0, 1'b1, 3'd6, a);
    chk("clr_err", int'(err_o), 0);
    wait_done(60);
    repeat (4) @(negedge clk_i);

    // Lock loss in RUN with a request on the same cycle.
    @(negedge clk_i);
    g = cyc + 1;
    glitch_cyc = g;
    for (int i = 0; i < 10; i++) begin
      if (cyc == g + 2) break;
      @(negedge clk_i);
    end
    cfg_i = 3'd7;
    cfg_vld_i = 1'b1;
    push(EV_SEL_DN, g + 3, 0);
    push(EV_RELOCK, g + 3, 0);
    push(EV_EN_DN, g + 5, 0);
    push(EV_EN_UP, g + 8, 0);
    push(EV_SEL_UP, g + 24, 3);
    chk("loss_rdy", int'(cfg_rdy_o), 0);
    chk("loss_busy", int'(busy_o), 0);
    @(negedge clk_i);
    cfg_vld_i = 1'b0;
    $display("xact lock-loss with cfg=7 held, cyc %0d", cyc);
    chk("loss_relock", int'(relock_o), 1);
    wait_done(60);
    repeat (4) @(negedge clk_i);
    glitch_cyc = -1;
    chk("loss_cfg_kept", int'(pll_cfg_o), 3);

    // Bypass from RUN.
    send(3'd0, M_RUN, 1'b1, 1'b0, 3'd3, a);
    wait_done(30);
    repeat (3) @(negedge clk_i);
    chk("byp_en", int'(pll_en_o), 0);
    chk("byp_rdy", int'(cfg_rdy_o), 1);
    chk("byp_busy", int'(busy_o), 0);

    // Reset while waiting for lock.
    send(3'd4, M_HALT, 1'b0, 1'b0, 3'd0, a);
    for (int i = 0; i < 20; i++) begin
      if (cyc >= a + 8) break;
      @(negedge clk_i);
    end
    wait_done(2);
    chk("halt_en_before", int'(pll_en_o), 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("post_rst_rdy", int'(cfg_rdy_o), 1);

    repeat (5) @(negedge clk_i);
    wait_done(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
